// File: rtl/alu_mc.sv
// Multi-cycle integer ALU for the EX stage: single-cycle logic/add/sub/slt, iterative MUL/DIVU/REMU.
// Define ALU_SLT_OVF_EN to make SLT overflow-corrected (true signed less-than).
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic [2:0]       ctlSignal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] quick;
    logic             slt_bit;
    logic             iterative;
`ifdef ALU_SLT_OVF_EN
    logic             ovf;
`endif

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    always_comb begin
        diff    = DataA + ~DataB + WIDTH'(1);
`ifdef ALU_SLT_OVF_EN
        ovf     = (DataA[WIDTH-1] != DataB[WIDTH-1]) && (diff[WIDTH-1] != DataA[WIDTH-1]);
        slt_bit = diff[WIDTH-1] ^ ovf;
`else
        slt_bit = diff[WIDTH-1];
`endif
        iterative = 1'b0;
        case (ctlSignal)
            OP_AND:  quick = DataA & DataB;
            OP_OR:   quick = DataA | DataB;
            OP_ADD:  quick = DataA + DataB;
            OP_SUB:  quick = diff;
            OP_SLT:  quick = {{(WIDTH-1){1'b0}}, slt_bit};
            default: begin
                quick     = '0;
                iterative = 1'b1;
            end
        endcase
    end

    // MUL: acc is the product, opa the shifting multiplicand, opb the shifting multiplier.
    // DIV: acc is the partial remainder, opa shifts dividend bits out and quotient bits in.
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] iter_res;

    always_comb begin
        mul_acc_nx = opb[0] ? acc + opa : acc;
        rem_shift  = {acc, opa[WIDTH-1]};
        fits       = rem_shift >= {1'b0, opb};
        rem_nx     = fits ? WIDTH'(rem_shift - {1'b0, opb}) : rem_shift[WIDTH-1:0];
        quo_nx     = {opa[WIDTH-2:0], fits};
        case (op_q)
            OP_MUL:  iter_res = mul_acc_nx;
            OP_DIVU: iter_res = quo_nx;
            default: iter_res = rem_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= OP_AND;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= ctlSignal;
                        if (iterative) begin
                            opa   <= DataA;
                            opb   <= DataB;
                            acc   <= '0;
                            count <= '0;
                            state <= BUSY;
                        end else begin
                            result <= quick;
                            zero   <= (quick == '0);
                            state  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (op_q == OP_MUL) begin
                        acc <= mul_acc_nx;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc <= rem_nx;
                        opa <= quo_nx;
                    end
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        result <= iter_res;
                        zero   <= (iter_res == '0);
                        count  <= '0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: a 32-bit and an 8-bit instance against a cycle-level behavioural model.
// Honours ALU_SLT_OVF_EN for the SLT expectations.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        iv   [2];
    logic        ordy [2];
    logic [2:0]  ctl  [2];
    logic [31:0] da   [2];
    logic [31:0] db   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        bsy  [2];
    logic        zr   [2];
    logic [31:0] res32;
    logic [7:0]  res8;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .DataA(da[0]), .DataB(db[0]), .ctlSignal(ctl[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .result(res32), .zero(zr[0]), .busy(bsy[0])
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .DataA(da[1][7:0]), .DataB(db[1][7:0]), .ctlSignal(ctl[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .result(res8), .zero(zr[1]), .busy(bsy[1])
    );

    function automatic int width_of(int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] res_of(int k);
        return (k == 0) ? res32 : {24'd0, res8};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions, done in 64-bit and masked.
    function automatic logic [63:0] model_op(int w, logic [2:0] op, logic [63:0] a0, logic [63:0] b0);
        logic [63:0] mask, a, b, sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = a0 & mask;
        b = b0 & mask;
        sa = a[w-1] ? (a | ~mask) : a;
        sb = b[w-1] ? (b | ~mask) : b;
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return (a + b) & mask;
            3'd3:    return (a * b) & mask;
            3'd4:    return (b == 0) ? mask : a / b;
            3'd5:    return (b == 0) ? a : a % b;
            3'd6:    return (a - b) & mask;
`ifdef ALU_SLT_OVF_EN
            default: return 64'($signed(sa) < $signed(sb));
`else
            default: return (((a - b) & mask) >> (w - 1)) & 64'd1;
`endif
        endcase
    endfunction

    // Model: m_wait counts remaining iteration cycles, m_done marks a presented result.
    int          m_wait [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    logic [63:0] m_res  [2] = '{64'd0, 64'd0};

    task automatic model_step(input int k);
        if (m_done[k]) begin
            if (ordy[k]) m_done[k] = 1'b0;
        end else if (m_wait[k] > 0) begin
            m_wait[k]--;
            if (m_wait[k] == 0) m_done[k] = 1'b1;
        end else if (iv[k]) begin
            m_res[k] = model_op(width_of(k), ctl[k], {32'd0, da[k]}, {32'd0, db[k]});
            if (ctl[k] inside {3'd3, 3'd4, 3'd5}) m_wait[k] = width_of(k);
            else m_done[k] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_wait[k] = 0;
                m_done[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d out_valid", k), {63'd0, ov[k]}, {63'd0, m_done[k]});
                check($sformatf("dut%0d in_ready", k), {63'd0, ir[k]},
                      {63'd0, rst_n && !m_done[k] && (m_wait[k] == 0)});
                check($sformatf("dut%0d busy", k), {63'd0, bsy[k]}, {63'd0, m_wait[k] > 0});
                if (m_done[k]) begin
                    check($sformatf("dut%0d result", k), {32'd0, res_of(k)}, m_res[k]);
                    check($sformatf("dut%0d zero", k), {63'd0, zr[k]}, {63'd0, m_res[k] == 0});
                end
            end
        end
    end

    task automatic wait_ready(input int k);
        int t = 0;
        while (!ir[k] && t < 60) begin
            @(negedge clk); #1;
            t++;
        end
        check("in_ready wait", {63'd0, ir[k]}, 64'd1);
    endtask

    // One full transaction with literal expectations; noise scrambles inputs while busy.
    task automatic apply_stimulus(input int k, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] expv,
                                  input int exp_lat, input int hold, input bit noise);
        int lat;
        int busy_cnt;
        wait_ready(k);
        iv[k] = 1'b1; ctl[k] = op; da[k] = a; db[k] = b;
        @(negedge clk); #1;
        iv[k] = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!ov[k] && lat < 100) begin
            if (bsy[k]) busy_cnt++;
            if (noise) begin
                iv[k] = 1'b1; da[k] = $urandom; db[k] = $urandom;
                ctl[k] = 3'($urandom); ordy[k] = 1'($urandom);
            end
            @(negedge clk); #1;
            lat++;
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b0;
        check_output(k, op, lat, busy_cnt, expv, exp_lat, hold);
    endtask

    task automatic check_output(input int k, input logic [2:0] op, input int lat, input int busy_cnt,
                                input logic [31:0] expv, input int exp_lat, input int hold);
        check($sformatf("op%0d latency", op), 64'(lat), 64'(exp_lat));
        check($sformatf("op%0d busy cycles", op), 64'(busy_cnt), 64'(exp_lat - 1));
        check($sformatf("op%0d result", op), {32'd0, res_of(k)}, {32'd0, expv});
        check($sformatf("op%0d zero", op), {63'd0, zr[k]}, {63'd0, expv == 0});
        check("in_ready low in DONE", {63'd0, ir[k]}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check("held out_valid", {63'd0, ov[k]}, 64'd1);
            check("held result", {32'd0, res_of(k)}, {32'd0, expv});
        end
        ordy[k] = 1'b1;
        @(negedge clk); #1;
        ordy[k] = 1'b0;
        check("out_valid drop", {63'd0, ov[k]}, 64'd0);
        check("in_ready after handshake", {63'd0, ir[k]}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; ctl[k] = 3'd0; da[k] = '0; db[k] = '0;
        end
        #3 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        check("reset result", {32'd0, res32}, 64'd0);
        check("reset zero", {63'd0, zr[0]}, 64'd0);
        check("reset out_valid", {63'd0, ov[0]}, 64'd0);
        check("reset busy", {63'd0, bsy[0]}, 64'd0);
        check("reset in_ready", {63'd0, ir[0]}, 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("in_ready after release", {63'd0, ir[0]}, 64'd1);

        apply_stimulus(0, 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0);
        apply_stimulus(0, 3'b110, 32'd5, 32'd5, 32'h0, 1, 0, 0);
        apply_stimulus(0, 3'b011, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33, 3, 1);
        apply_stimulus(0, 3'b100, 32'd100, 32'd7, 32'd14, 33, 0, 0);
        apply_stimulus(0, 3'b101, 32'd100, 32'd7, 32'd2, 33, 0, 1);
        apply_stimulus(0, 3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 1, 0);
        apply_stimulus(0, 3'b101, 32'd9, 32'd0, 32'd9, 33, 0, 0);
`ifdef ALU_SLT_OVF_EN
        apply_stimulus(0, 3'b111, 32'h8000_0000, 32'h1, 32'd1, 1, 0, 0);
        apply_stimulus(0, 3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
`else
        apply_stimulus(0, 3'b111, 32'h8000_0000, 32'h1, 32'd0, 1, 0, 0);
        apply_stimulus(0, 3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1, 0, 0);
`endif
        apply_stimulus(0, 3'b111, 32'd3, 32'd7, 32'd1, 1, 0, 0);
        apply_stimulus(0, 3'b001, 32'hA500_00F0, 32'h0A00_0F00, 32'hAF00_0FF0, 1, 0, 0);

        // Abandon a DIVU ten cycles into BUSY.
        wait_ready(0);
        iv[0] = 1'b1; ctl[0] = 3'b100; da[0] = 32'd1000; db[0] = 32'd3;
        @(negedge clk); #1;
        iv[0] = 1'b0;
        repeat (9) begin
            @(negedge clk); #1;
        end
        check("busy before reset", {63'd0, bsy[0]}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {63'd0, bsy[0]}, 64'd0);
        check("mid reset out_valid", {63'd0, ov[0]}, 64'd0);
        check("mid reset result", {32'd0, res32}, 64'd0);
        check("mid reset in_ready", {63'd0, ir[0]}, 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1 check("in_ready after mid release", {63'd0, ir[0]}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        check("no result after abandon", {63'd0, seen}, 64'd0);
        apply_stimulus(0, 3'b010, 32'd2, 32'd3, 32'd5, 1, 0, 0);

        apply_stimulus(1, 3'b000, 32'hF0, 32'h3C, 32'h30, 1, 0, 0);
        apply_stimulus(1, 3'b011, 32'h0F, 32'h11, 32'hFF, 9, 1, 0);
        apply_stimulus(1, 3'b100, 32'd200, 32'd3, 32'd66, 9, 0, 0);
        apply_stimulus(1, 3'b101, 32'd200, 32'd3, 32'd2, 9, 0, 1);
        apply_stimulus(1, 3'b010, 32'hFF, 32'h01, 32'h00, 1, 0, 0);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised-width integer ALU for the EX stage of the 5-stage pipeline.
- Covers the existing single-cycle operations: AND, OR, ADD, SUB, SLT.
- Adds iterative unsigned multiply, divide and remainder.
- Operands are accepted and results returned over valid/ready handshakes, so the hazard unit can stall the pipeline while a long operation runs.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  block can accept a new operation.
- DataA  in  WIDTH  operand A.
- DataB  in  WIDTH  operand B.
- ctlSignal  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 DIVU, 101 REMU, 110 SUB, 111 SLT.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- zero  out  1  1 when result == 0.
- busy  out  1  1 in state BUSY (iterative op in progress).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; result=0, zero=0, out_valid=0, busy=0, counter=0.
  - in_ready deasserts immediately while rst_n is low and returns to 1 in the first cycle after release.
  - Reset during BUSY or DONE abandons the operation; no result is produced.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE) and rst_n.
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready, DataA/DataB/ctlSignal are captured.
  - AND/OR/ADD/SUB/SLT: result computed and registered → DONE. out_valid rises on the next edge (latency 1).
  - MUL/DIVU/REMU: operands loaded into working registers, counter=0 → BUSY.
- BUSY: one iteration per cycle for WIDTH cycles; on the cycle counter reaches WIDTH-1, result registered → DONE.
  - Accept-to-out_valid latency is WIDTH+1 cycles.
  - in_valid is ignored in BUSY; inputs may change freely without affecting the operation.
- DONE:
  - result and zero are held stable until out_ready.
  - On out_ready=1 → IDLE; the next operation can be accepted one cycle later (no same-cycle accept).
  - out_ready in other states is ignored.
- Arithmetic (all modulo 2^WIDTH):
  - ADD = A+B. SUB = A+~B+1.
  - SLT = {WIDTH-1 zeros, sign bit of (A-B)}. This is the raw subtraction sign bit, with no overflow correction; it matches the current pipeline semantics.
  - MUL: shift-add, low WIDTH bits of the unsigned product.
  - DIVU: restoring division, unsigned quotient.
  - REMU: restoring division, unsigned remainder.
- Divide by zero (B==0): DIVU result = all ones; REMU result = A. Latency and state sequence are unchanged.
- zero = (result==0), registered with result, valid whenever out_valid=1.

Optional Feature:
- ALU_SLT_OVF_EN
  - Defined: SLT result = sign(A-B) XOR overflow(A-B), i.e. correct signed less-than for all operands.
  - Not defined: SLT uses the raw sign bit only (wrong when A-B overflows).
  - No other operation is affected.

Test Plan (WIDTH=32 unless noted):
- ADD 0x7FFF_FFFF + 0x1, out_ready=1: out_valid exactly 1 cycle after accept, result=0x8000_0000, zero=0. Then SUB 5−5: result=0, zero=1.
- MUL 0x0001_0003 × 0x0002_0005, out_ready held 0 for 3 cycles after out_valid: out_valid at cycle 33 after accept, result=0x000B_000F held stable, busy=1 for 32 cycles, in_ready=0 throughout.
- DIVU 100/7 → result 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFF_FFFF; REMU 9/0 → 9. Each at latency 33.
- SLT 0x8000_0000 vs 0x0000_0001:
  - Macro off: raw sign bit = 0, result=0.
  - Macro on: result=1.
  - Both builds: SLT 3 vs 7 → result=1.
- Reset mid-operation: assert rst_n=0 at BUSY cycle 10 of a DIVU. Outputs clear immediately; no out_valid appears afterwards. A new ADD 2+3 accepted after release returns 5.
- Back-to-back with WIDTH=8: AND 0xF0&0x3C → 0x30, then MUL 0x0F×0x11 → 0xFF at latency 9. Check in_ready gap of one cycle after each out_ready handshake.
